// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between instruction
// fetch (read-only) and the load/store unit, absorbing the memory read latency.
module mem_access_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_valid,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int               CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic             OWN_IF   = 1'b0;
    localparam logic             OWN_LS   = 1'b1;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_valid_q, if_valid_d;
    logic                ls_valid_q, ls_valid_d;
    logic                busy_q, busy_d;
    logic                grant_ls_s;

    // Next-state, latched request fields and next output values.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        grant_ls_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    // On a tie the requester that did not win last time goes first.
                    grant_ls_s   = ls_req && (!if_req || (last_grant_q == OWN_IF));
                    owner_d      = grant_ls_s;
                    last_grant_d = grant_ls_s;
                    addr_d       = grant_ls_s ? ls_addr : if_addr;
                    we_d         = grant_ls_s && ls_we;
                    wdata_d      = grant_ls_s ? ls_wdata : {DATA_W{1'b0}};
                    state_d      = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = DONE;
                    if (owner_q == OWN_LS) begin
                        ls_rdata_d = mem_read_data;
                    end else begin
                        if_rdata_d = mem_read_data;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        mem_read_d    = (state_d == ACCESS) && !we_d;
        mem_write_d   = (state_d == ACCESS) && we_d;
        mem_address_d = (state_d == ACCESS) ? addr_d : {ADDR_W{1'b0}};
        mem_wdata_d   = ((state_d == ACCESS) && we_d) ? wdata_d : {DATA_W{1'b0}};
        if_valid_d    = (state_d == DONE) && (owner_d == OWN_IF);
        ls_valid_d    = (state_d == DONE) && (owner_d == OWN_LS);
        busy_d        = (state_d != IDLE);
    end

    // State, latched request and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_IF;
            last_grant_q  <= OWN_LS;
            addr_q        <= {ADDR_W{1'b0}};
            we_q          <= 1'b0;
            wdata_q       <= {DATA_W{1'b0}};
            cnt_q         <= CNT_ZERO;
            if_rdata_q    <= {DATA_W{1'b0}};
            ls_rdata_q    <= {DATA_W{1'b0}};
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= {ADDR_W{1'b0}};
            mem_wdata_q   <= {DATA_W{1'b0}};
            if_valid_q    <= 1'b0;
            ls_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            if_rdata_q    <= if_rdata_d;
            ls_rdata_q    <= ls_rdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            if_valid_q    <= if_valid_d;
            ls_valid_q    <= ls_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign if_rdata       = if_rdata_q;
    assign ls_rdata       = ls_rdata_q;
    assign if_valid       = if_valid_q;
    assign ls_valid       = ls_valid_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_wdata_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench: two arbiters (READ_LAT 1 and 3) share stimulus, each with its
// own memory model; sel3 picks which one the checks observe.
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = 32'h0;
    logic [31:0] ls_wdata = 32'h0;
    logic        sel3 = 1'b0;

    logic [31:0] a_if_rdata, a_ls_rdata, a_mem_address, a_mem_write_data, a_rd;
    logic        a_if_valid, a_ls_valid, a_mem_read, a_mem_write, a_busy;
    logic [31:0] b_if_rdata, b_ls_rdata, b_mem_address, b_mem_write_data, b_rd;
    logic        b_if_valid, b_ls_valid, b_mem_read, b_mem_write, b_busy;

    logic [31:0] o_if_rdata, o_ls_rdata, o_mem_address, o_mem_write_data;
    logic        o_if_valid, o_ls_valid, o_mem_read, o_mem_write, o_busy;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] b_s0, b_s1;
    int          total = 0;
    int          bad = 0;
    int          both_hi = 0;

    always #5 clk = ~clk;

    mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_valid(a_if_valid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(a_ls_rdata), .ls_valid(a_ls_valid),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_address(a_mem_address),
        .mem_write_data(a_mem_write_data), .mem_read_data(a_rd), .busy(a_busy)
    );

    mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(b_ls_rdata), .ls_valid(b_ls_valid),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_address(b_mem_address),
        .mem_write_data(b_mem_write_data), .mem_read_data(b_rd), .busy(b_busy)
    );

    // Memory with a one-edge registered read; reset preloads word 8.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= (i == 8) ? 32'h12345678 : 32'h0;
        end else if (a_mem_write) begin
            mem_a[a_mem_address[3:0]] <= a_mem_write_data;
        end
        a_rd <= mem_a[a_mem_address[3:0]];
    end

    // Memory with a three-edge read pipeline for the READ_LAT=3 instance.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= (i == 8) ? 32'h12345678 : 32'h0;
        end else if (b_mem_write) begin
            mem_b[b_mem_address[3:0]] <= b_mem_write_data;
        end
        b_s0 <= mem_b[b_mem_address[3:0]];
        b_s1 <= b_s0;
        b_rd <= b_s1;
    end

    // Counts any cycle where a memory sees read and write together.
    always @(posedge clk) begin
        if ((a_mem_read && a_mem_write) || (b_mem_read && b_mem_write)) both_hi <= both_hi + 1;
    end

    always_comb begin
        o_if_rdata       = sel3 ? b_if_rdata       : a_if_rdata;
        o_ls_rdata       = sel3 ? b_ls_rdata       : a_ls_rdata;
        o_mem_address    = sel3 ? b_mem_address    : a_mem_address;
        o_mem_write_data = sel3 ? b_mem_write_data : a_mem_write_data;
        o_if_valid       = sel3 ? b_if_valid       : a_if_valid;
        o_ls_valid       = sel3 ? b_ls_valid       : a_ls_valid;
        o_mem_read       = sel3 ? b_mem_read       : a_mem_read;
        o_mem_write      = sel3 ? b_mem_write      : a_mem_write;
        o_busy           = sel3 ? b_busy           : a_busy;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Issue one request from IDLE, hold it until its valid, then check timing and data.
    task automatic run_req(input string tag, input logic is_ls, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic [31:0] exp_rdata);
        int lat = 0;
        int nrd = 0;
        int nwr = 0;
        int other = 0;
        logic [31:0] seen_addr = 32'h0;
        logic [31:0] seen_wdata = 32'h0;
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            tick();
            if (o_mem_read) begin nrd++; seen_addr = o_mem_address; end
            if (o_mem_write) begin nwr++; seen_addr = o_mem_address; seen_wdata = o_mem_write_data; end
            if (is_ls ? o_ls_valid : o_if_valid) begin
                lat = c; if_req = 1'b0; ls_req = 1'b0;
            end
            if (is_ls ? o_if_valid : o_ls_valid) other++;
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        tick();
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " reads"}, 64'(nrd), we ? 64'd0 : 64'd1);
        check({tag, " writes"}, 64'(nwr), we ? 64'd1 : 64'd0);
        check({tag, " address"}, 64'(seen_addr), 64'(addr));
        check({tag, " other valid"}, 64'(other), 64'd0);
        if (we) check({tag, " wdata"}, 64'(seen_wdata), 64'(wdata));
        else    check({tag, " rdata"}, 64'(is_ls ? o_ls_rdata : o_if_rdata), 64'(exp_rdata));
    endtask

    initial begin
        int nval;
        int idle;
        int last;
        int cnt;
        logic [3:0] order;

        // Reset state, observed while reset is still held.
        tick();
        tick();
        check("rst busy", 64'(o_busy), 64'd0);
        check("rst mem_read", 64'(o_mem_read), 64'd0);
        check("rst mem_write", 64'(o_mem_write), 64'd0);
        check("rst mem_address", 64'(o_mem_address), 64'd0);
        check("rst valids", 64'({o_if_valid, o_ls_valid}), 64'd0);
        check("rst if_rdata", 64'(o_if_rdata), 64'd0);
        check("rst ls_rdata", 64'(o_ls_rdata), 64'd0);
        reset = 1'b0;

        run_req("if rd8", 1'b0, 1'b0, 32'd8, 32'h0, 3, 32'h12345678);
        run_req("ls wr4", 1'b1, 1'b1, 32'd4, 32'hDEADBEEF, 2, 32'h0);
        run_req("ls rd4", 1'b1, 1'b0, 32'd4, 32'h0, 3, 32'hDEADBEEF);
        check("if_rdata kept", 64'(o_if_rdata), 64'h12345678);

        // Contention straight out of reset: IF, LS, IF, LS with one IDLE gap each.
        do_reset();
        if_req = 1'b1; if_addr = 32'd8;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd8;
        nval = 0; idle = 0; last = 0; order = 4'b0000;
        for (int c = 1; c <= 40 && nval < 4; c++) begin
            tick();
            if (!o_busy) idle++;
            if (o_if_valid) begin order = {order[2:0], 1'b0}; nval++; end
            if (o_ls_valid) begin order = {order[2:0], 1'b1}; nval++; end
            if (nval == 4) last = c;
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        tick();
        check("rr order", 64'(order), 64'h5);
        check("rr last valid cycle", 64'(last), 64'd15);
        check("rr idle gaps", 64'(idle), 64'd3);
        check("rr ls_rdata", 64'(o_ls_rdata), 64'h12345678);

        // Reset in the WAIT cycle of an LS read.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd8;
        tick();
        tick();
        check("wait busy", 64'(o_busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid rst busy", 64'(o_busy), 64'd0);
        check("mid rst mem_address", 64'(o_mem_address), 64'd0);
        check("mid rst ls_rdata", 64'(o_ls_rdata), 64'd0);
        ls_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (o_ls_valid || o_busy) cnt++;
        end
        check("no activity after rst", 64'(cnt), 64'd0);
        run_req("if after rst", 1'b0, 1'b0, 32'd8, 32'h0, 3, 32'h12345678);

        // LS request withdrawn while fetch owns the memory.
        if_req = 1'b1; if_addr = 32'd8;
        tick();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd4;
        tick();
        tick();
        check("drop if_valid", 64'(o_if_valid), 64'd1);
        if_req = 1'b0;
        ls_req = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o_ls_valid || o_mem_read || o_mem_write) cnt++;
        end
        check("dropped ls ignored", 64'(cnt), 64'd0);

        // Longer read latency instance.
        do_reset();
        sel3 = 1'b1;
        run_req("lat3 if rd8", 1'b0, 1'b0, 32'd8, 32'h0, 5, 32'h12345678);

        check("rd/wr exclusive", 64'(both_hi), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single-port data_memory between two requesters: instruction fetch (read-only) and the load/store unit (read or write).
- Sits between the execution-cycle control path and the memory. It owns mem_read, mem_write, address and write-data toward memory.
- Serialises accesses with a req/valid handshake and round-robin priority. It absorbs the memory's registered read latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- READ_LAT, 1, clock edges from the mem_read issue cycle until mem_read_data is valid; legal values are >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held high until if_valid.
- if_addr  input  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  output  DATA_W  fetch read data; valid when if_valid is high.
- if_valid  output  1  one-cycle completion pulse for fetch.
- ls_req  input  1  load/store request; held high until ls_valid.
- ls_we  input  1  1 = write, 0 = read; stable while ls_req is high.
- ls_addr  input  ADDR_W  load/store address.
- ls_wdata  input  DATA_W  store data.
- ls_rdata  output  DATA_W  load data; valid when ls_valid is high.
- ls_valid  output  1  one-cycle completion pulse for load/store (reads and writes).
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_address  output  ADDR_W  memory address.
- mem_write_data  output  DATA_W  memory write data.
- mem_read_data  input  DATA_W  memory read data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, last_grant = LS, so fetch wins the first tie.
  - All outputs 0, including rdata registers and mem_address.
  - Any in-flight access is discarded: no valid pulse, no pending grant. A write that is mid-ACCESS may or may not reach memory; that outcome is not checked.
- FSM states are IDLE, ACCESS, WAIT and DONE. All outputs are registered or decoded from the state and latched registers only; there are no combinational paths from input to output.
- IDLE:
  - Requests are sampled at the clock edge.
  - Only one request present: grant it.
  - Both requests present: grant the requester that is not last_grant.
  - On grant, latch the owner, address, we and wdata, update last_grant, and go to ACCESS.
  - No request present: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_address = latched address.
  - Read: mem_read = 1, next state WAIT.
  - Write (LS only): mem_write = 1, mem_write_data = latched data, next state DONE.
  - mem_read and mem_write are never high together. Both are 0 outside ACCESS.
- WAIT:
  - A down-counter loaded with READ_LAT-1 on entry decrements each cycle.
  - In the cycle where the count is 0, mem_read_data is captured into the owner's rdata register, and the next state is DONE.
  - WAIT therefore lasts READ_LAT cycles.
- DONE (exactly 1 cycle):
  - The owner's valid = 1.
  - Next state is always IDLE; no grant is made in DONE.
  - The requester drops req in the cycle after valid. A req still high in IDLE is treated as a new request.
- The rdata registers hold their value until the next read for the same owner. The non-owner's rdata is never disturbed.
- Latency from the edge that samples req to the valid cycle:
  - Read: READ_LAT+2 cycles (3 with default parameters).
  - Write: 2 cycles.
- Throughput: one access per READ_LAT+3 cycles (reads) or per 3 cycles (writes). Under contention, accesses strictly alternate between requesters, so neither starves.
- A req that drops before it is granted is ignored without error. Address or data changes after grant have no effect.
- A requester asserting req with ls_we on the fetch port is not possible; fetch is read-only.

Test Plan:
- Preload memory[8] = 32'h12345678; if_req = 1, if_addr = 8 → mem_read pulses for 1 cycle with mem_address = 8; if_valid pulses 3 cycles after the sampling edge; if_rdata = 32'h12345678; ls_valid stays 0.
- LS write: ls_we = 1, ls_addr = 4, ls_wdata = 32'hDEADBEEF → a single mem_write cycle; ls_valid 2 cycles after sampling. Then an LS read of address 4 → ls_rdata = 32'hDEADBEEF.
- Both req asserted together out of reset → fetch granted first and LS second. Holding both continuously gives a grant order of IF, LS, IF, LS; busy stays high except in the one-cycle IDLE gaps.
- Reset asserted during WAIT of an LS read → all outputs 0 immediately; no ls_valid. After release, a new if_req completes normally with fetch priority.
- READ_LAT = 3, fetch read of memory[8] → WAIT lasts 3 cycles; if_valid 5 cycles after sampling; data = 32'h12345678.
- LS req dropped before grant while fetch is busy → no LS access is issued; no ls_valid.
